// File: rtl/switch_ingress_arb.sv
// Two-requester ingress stage for the address-split switch.
// Each requester is buffered in its own FIFO; a round-robin arbiter pops at most one
// entry per cycle into a registered valid/addr/data stream that is zeroed when idle.
module switch_ingress_arb #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [ADDR_WIDTH-1:0] in0_addr,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    input  logic [ADDR_WIDTH-1:0] in1_addr,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  out_en,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic [CNT_WIDTH-1:0]  fifo0_count,
    output logic [CNT_WIDTH-1:0]  fifo1_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);

    logic [ENT_W-1:0] mem0 [FIFO_DEPTH];
    logic [ENT_W-1:0] mem1 [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;
    logic             rr_last;
    logic             push0, push1;
    logic             gnt0, gnt1;

    // Ready comes only from the registered count, so a full FIFO refuses even while popping.
    assign in0_ready = (fifo0_count != CNT_FULL);
    assign in1_ready = (fifo1_count != CNT_FULL);
    assign push0     = in0_valid && in0_ready;
    assign push1     = in1_valid && in1_ready;

    // Round-robin grant from registered occupancy; the lone non-empty FIFO always wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (out_en) begin
            if ((fifo0_count != '0) && (fifo1_count != '0)) begin
                gnt0 = rr_last;
                gnt1 = !rr_last;
            end else begin
                gnt0 = (fifo0_count != '0);
                gnt1 = (fifo1_count != '0);
            end
        end
    end

    // Entry storage; contents need no reset because counts gate every read.
    always_ff @(posedge clk) begin
        if (push0) mem0[wr_ptr0] <= {in0_addr, in0_data};
        if (push1) mem1[wr_ptr1] <= {in1_addr, in1_data};
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr0     <= '0;
            rd_ptr0     <= '0;
            wr_ptr1     <= '0;
            rd_ptr1     <= '0;
            fifo0_count <= '0;
            fifo1_count <= '0;
        end else begin
            if (push0) wr_ptr0 <= wr_ptr0 + PTR_W'(1);
            if (gnt0)  rd_ptr0 <= rd_ptr0 + PTR_W'(1);
            if (push1) wr_ptr1 <= wr_ptr1 + PTR_W'(1);
            if (gnt1)  rd_ptr1 <= rd_ptr1 + PTR_W'(1);
            case ({push0, gnt0})
                2'b10:   fifo0_count <= fifo0_count + CNT_WIDTH'(1);
                2'b01:   fifo0_count <= fifo0_count - CNT_WIDTH'(1);
                default: fifo0_count <= fifo0_count;
            endcase
            case ({push1, gnt1})
                2'b10:   fifo1_count <= fifo1_count + CNT_WIDTH'(1);
                2'b01:   fifo1_count <= fifo1_count - CNT_WIDTH'(1);
                default: fifo1_count <= fifo1_count;
            endcase
        end
    end

    // Arbiter history; reset to 1 so input 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (gnt0 || gnt1) begin
            rr_last <= gnt1;
        end
    end

    // Output register: popped entry on a grant, all-zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (gnt0) begin
            valid         <= 1'b1;
            {addr, data}  <= mem0[rd_ptr0];
        end else if (gnt1) begin
            valid         <= 1'b1;
            {addr, data}  <= mem1[rd_ptr1];
        end else begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end
    end

endmodule

// File: tb/tb_switch_ingress_arb.sv
// Bench for switch_ingress_arb: queue-based reference model checked every cycle,
// a vector table for the contention sequence, and directed multi-cycle corner cases.
module tb_switch_ingress_arb;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int EW    = AW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in0_valid = 1'b0, in1_valid = 1'b0, out_en = 1'b0;
    logic [AW-1:0] in0_addr = '0, in1_addr = '0;
    logic [DW-1:0] in0_data = '0, in1_data = '0;
    logic          in0_ready, in1_ready, valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [CW-1:0] fifo0_count, fifo1_count;

    switch_ingress_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_addr(in0_addr), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_addr(in1_addr), .in1_data(in1_data),
        .out_en(out_en), .valid(valid), .addr(addr), .data(data),
        .fifo0_count(fifo0_count), .fifo1_count(fifo1_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {a, d};
    endfunction

    // Reference model: per-input queues act as the scoreboard; entries are pushed when
    // accepted and popped into the expected output when the model grants.
    logic [EW-1:0] q0[$];
    logic [EW-1:0] q1[$];
    bit            rr_m;
    bit            exp_valid;
    logic [EW-1:0] exp_ent;
    bit            g0, g1, a0, a1;

    always @(posedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            rr_m      = 1'b1;
            exp_valid = 1'b0;
            exp_ent   = '0;
        end else begin
            a0 = in0_valid && (q0.size() != DEPTH);
            a1 = in1_valid && (q1.size() != DEPTH);
            g0 = out_en && (q0.size() > 0) && ((q1.size() == 0) || rr_m);
            g1 = out_en && (q1.size() > 0) && !g0;
            exp_valid = g0 || g1;
            exp_ent   = '0;
            if (g0) begin exp_ent = q0.pop_front(); rr_m = 1'b0; end
            if (g1) begin exp_ent = q1.pop_front(); rr_m = 1'b1; end
            if (a0) q0.push_back({in0_addr, in0_data});
            if (a1) q1.push_back({in1_addr, in1_data});
        end
    end

    bit            mon_en = 1'b0;
    logic [EW-1:0] issue_log[$];

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_valid", valid, exp_valid);
            check("mon_addr", addr, exp_ent[EW-1:DW]);
            check("mon_data", data, exp_ent[DW-1:0]);
            check("mon_cnt0", fifo0_count, q0.size());
            check("mon_cnt1", fifo1_count, q1.size());
            check("mon_rdy0", in0_ready, q0.size() != DEPTH);
            check("mon_rdy1", in1_ready, q1.size() != DEPTH);
            if (valid) issue_log.push_back({addr, data});
        end
    end

    typedef struct {
        bit            v0;
        logic [EW-1:0] e0;
        bit            v1;
        logic [EW-1:0] e1;
        bit            oe;
        int            c0;
        int            c1;
        bit            r0;
        bit            r1;
    } vec_t;

    vec_t tbl[12];

    task automatic drive(input bit v0, input logic [EW-1:0] e0, input bit v1,
                         input logic [EW-1:0] e1, input bit oe);
        in0_valid = v0;
        {in0_addr, in0_data} = e0;
        in1_valid = v1;
        {in1_addr, in1_data} = e1;
        out_en = oe;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [EW-1:0] ea, eb;
        int k0, k1, n0, n1;
        bit r0, r1;

        // Contention table: preload both FIFOs with out_en low, then drain alternately.
        for (int i = 0; i < 4; i++) begin
            ea = mk(8'h10 + 8'(i), 16'hA000 + 16'(i));
            eb = mk(8'h20 + 8'(i), 16'hB000 + 16'(i));
            tbl[i] = '{1'b1, ea, 1'b1, eb, 1'b0, i + 1, i + 1, i < 3, i < 3};
        end
        tbl[4]  = '{1'b0, '0, 1'b0, '0, 1'b1, 3, 4, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, '0, 1'b0, '0, 1'b1, 3, 3, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, '0, 1'b0, '0, 1'b1, 2, 3, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, '0, 1'b0, '0, 1'b1, 2, 2, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, '0, 1'b0, '0, 1'b1, 1, 2, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, '0, 1'b0, '0, 1'b1, 1, 1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, '0, 1'b0, '0, 1'b1, 0, 1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, '0, 1'b0, '0, 1'b1, 0, 0, 1'b1, 1'b1};

        // Reset state
        drive(0, '0, 0, '0, 0);
        rst_n = 1'b0;
        repeat (2) cyc();
        check("rst_valid", valid, 0);
        check("rst_addr", addr, 0);
        check("rst_data", data, 0);
        check("rst_cnt0", fifo0_count, 0);
        check("rst_cnt1", fifo1_count, 0);
        check("rst_rdy0", in0_ready, 1);
        check("rst_rdy1", in1_ready, 1);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        cyc();

        // Single transfer: valid appears after the edge following the push edge
        drive(1, mk(8'h12, 16'hABCD), 0, '0, 1);
        cyc();
        drive(0, '0, 0, '0, 1);
        check("t1_cnt_after_push", fifo0_count, 1);
        check("t1_valid_early", valid, 0);
        cyc();
        check("t1_valid", valid, 1);
        check("t1_addr", addr, 8'h12);
        check("t1_data", data, 16'hABCD);
        check("t1_cnt_after_pop", fifo0_count, 0);
        cyc();
        check("t1_valid_pulse_end", valid, 0);

        // Contention: fresh reset so input 0 wins first
        drive(0, '0, 0, '0, 0);
        pulse_reset();
        issue_log.delete();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v0, tbl[i].e0, tbl[i].v1, tbl[i].e1, tbl[i].oe);
            cyc();
            check("t2_cnt0", fifo0_count, tbl[i].c0);
            check("t2_cnt1", fifo1_count, tbl[i].c1);
            check("t2_rdy0", in0_ready, tbl[i].r0);
            check("t2_rdy1", in1_ready, tbl[i].r1);
        end
        drive(0, '0, 0, '0, 0);
        cyc();
        check("t2_issued", issue_log.size(), 8);
        for (int i = 0; i < 8 && i < issue_log.size(); i++) begin
            ea = (i % 2 == 0) ? mk(8'h10 + 8'(i / 2), 16'hA000 + 16'(i / 2))
                              : mk(8'h20 + 8'(i / 2), 16'hB000 + 16'(i / 2));
            check("t2_order", issue_log[i], ea);
        end

        // Full boundary on input 1
        for (int k = 0; k < 6; k++) begin
            drive(0, '0, 1, mk(8'h30 + 8'(k), 16'hC000 + 16'(k)), 0);
            cyc();
            check("t3_cnt1", fifo1_count, (k + 1 < 4) ? k + 1 : 4);
            check("t3_rdy1", in1_ready, (k + 1 < 4));
        end
        drive(0, '0, 0, '0, 1);
        issue_log.delete();
        repeat (6) cyc();
        drive(0, '0, 0, '0, 0);
        cyc();
        check("t3_issued", issue_log.size(), 4);
        for (int i = 0; i < 4 && i < issue_log.size(); i++)
            check("t3_order", issue_log[i], mk(8'h30 + 8'(i), 16'hC000 + 16'(i)));

        // Stall mid-stream
        for (int k = 0; k < 4; k++) begin
            drive(1, mk(8'h40 + 8'(k), 16'hD000 + 16'(k)), 0, '0, 0);
            cyc();
        end
        drive(0, '0, 0, '0, 1);
        issue_log.delete();
        repeat (2) cyc();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) drive(1, mk(8'h44, 16'hD004), 0, '0, 0);
            else        drive(0, '0, 0, '0, 0);
            cyc();
            check("t4_stall_valid", valid, 0);
            check("t4_stall_addr", addr, 0);
            check("t4_stall_data", data, 0);
            check("t4_stall_cnt0", fifo0_count, 3);
        end
        drive(0, '0, 0, '0, 1);
        repeat (6) cyc();
        drive(0, '0, 0, '0, 0);
        cyc();
        check("t4_issued", issue_log.size(), 5);
        for (int i = 0; i < 5 && i < issue_log.size(); i++)
            check("t4_order", issue_log[i], mk(8'h40 + 8'(i), 16'hD000 + 16'(i)));

        // Steady state: both inputs offer every cycle, values advance only on acceptance
        issue_log.delete();
        k0 = 0;
        k1 = 0;
        for (int c = 0; c < 24; c++) begin
            r0 = in0_ready;
            r1 = in1_ready;
            drive(1, mk(8'h50, 16'h5000 + 16'(k0)), 1, mk(8'h60, 16'h6000 + 16'(k1)), 1);
            cyc();
            if (r0) k0++;
            if (r1) k1++;
            if (c >= 1) check("t5_valid", valid, 1);
            check("t5_bound0", fifo0_count <= DEPTH, 1);
            check("t5_bound1", fifo1_count <= DEPTH, 1);
        end
        drive(0, '0, 0, '0, 1);
        repeat (10) cyc();
        drive(0, '0, 0, '0, 0);
        cyc();
        check("t5_drained0", fifo0_count, 0);
        check("t5_drained1", fifo1_count, 0);
        check("t5_total", issue_log.size(), k0 + k1);
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < issue_log.size(); i++) begin
            if (issue_log[i][EW-1:DW] == 8'h50) begin
                check("t5_seq0", issue_log[i][DW-1:0], 16'h5000 + 16'(n0));
                n0++;
            end else begin
                check("t5_seq1", issue_log[i], mk(8'h60, 16'h6000 + 16'(n1)));
                n1++;
            end
            if (i > 0 && i < 20)
                check("t5_alternate", issue_log[i][EW-1:DW] != issue_log[i-1][EW-1:DW], 1);
        end
        check("t5_count0", n0, k0);
        check("t5_count1", n1, k1);

        // Reset mid-operation flushes both FIFOs and restores input 0 priority
        for (int k = 0; k < 3; k++) begin
            drive(1, mk(8'h70 + 8'(k), 16'h7000 + 16'(k)), 1, mk(8'h80 + 8'(k), 16'h8000 + 16'(k)), 0);
            cyc();
        end
        check("t6_pre_cnt0", fifo0_count, 3);
        check("t6_pre_cnt1", fifo1_count, 3);
        drive(0, '0, 0, '0, 0);
        pulse_reset();
        check("t6_cnt0", fifo0_count, 0);
        check("t6_cnt1", fifo1_count, 0);
        check("t6_valid", valid, 0);
        check("t6_rdy0", in0_ready, 1);
        check("t6_rdy1", in1_ready, 1);
        issue_log.delete();
        drive(1, mk(8'h79, 16'h7009), 1, mk(8'h89, 16'h8009), 0);
        cyc();
        drive(0, '0, 0, '0, 1);
        repeat (2) cyc();
        drive(0, '0, 0, '0, 0);
        cyc();
        check("t6_issued", issue_log.size(), 2);
        if (issue_log.size() >= 2) begin
            check("t6_first", issue_log[0], mk(8'h79, 16'h7009));
            check("t6_second", issue_log[1], mk(8'h89, 16'h8009));
        end

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
